// File: rtl/exls_pipe_reg.sv
// exls_pipe_reg: EX -> LS pipeline register with a two-entry skid buffer.
// Main entry M drives the LS side directly from flops; skid entry S catches
// the single accept that can slip in while LS stalls, because ex_ready_o is
// registered. Empty slots are presented as a canonical NOP. The block also
// records the instruction/address that left LS in the previous cycle for
// store-to-load forwarding.
module exls_pipe_reg #(
    parameter int              XLEN      = 64,
    parameter int              ILEN      = 32,
    parameter logic [ILEN-1:0] NOP_INSTR = ILEN'(32'h0000_0013)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush_i,
    input  logic            ex_valid_i,
    output logic            ex_ready_o,
    input  logic [XLEN-1:0] ex_pc_i,
    input  logic [ILEN-1:0] ex_instr_i,
    input  logic [XLEN-1:0] ex_alures_i,
    input  logic [XLEN-1:0] ex_rs2_i,
    output logic            ls_valid_o,
    input  logic            ls_ready_i,
    output logic [XLEN-1:0] ls_pc_o,
    output logic [ILEN-1:0] ls_instr_o,
    output logic [XLEN-1:0] ls_alures_o,
    output logic [XLEN-1:0] ls_rs2_o,
    output logic [ILEN-1:0] ls_instr_last_o,
    output logic [XLEN-1:0] ls_alures_last_o
);

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [ILEN-1:0] instr;
        logic [XLEN-1:0] alures;
        logic [XLEN-1:0] rs2;
    } entry_t;

    // Encoding is {m_valid, s_valid}; 2'b01 (skid without main) is unreachable.
    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        BUSY  = 2'b10,
        FULL  = 2'b11
    } state_t;

    // A vacant slot holds a NOP with zeroed fields so LS decode sees no memory op.
    localparam entry_t VACANT = '{pc: '0, instr: NOP_INSTR, alures: '0, rs2: '0};

    state_t state;
    entry_t m_q;
    entry_t s_q;
    entry_t ex_entry;
    logic   m_valid;
    logic   acc;
    logic   deq;

    assign ex_entry = '{pc: ex_pc_i, instr: ex_instr_i, alures: ex_alures_i, rs2: ex_rs2_i};
    assign m_valid  = state[1];

    // A flush drops any offer in the same cycle, but a dequeue still completes.
    assign acc = ex_valid_i & ex_ready_o & ~flush_i;
    assign deq = m_valid & ls_ready_i;

    // LS side is driven straight from the M flops; no logic between flop and port.
    assign ls_valid_o  = m_valid;
    assign ls_pc_o     = m_q.pc;
    assign ls_instr_o  = m_q.instr;
    assign ls_alures_o = m_q.alures;
    assign ls_rs2_o    = m_q.rs2;

    // Handshake FSM, storage moves, registered ready and last-entry tracking.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: sequential state uses non-blocking assignments so every flop
            // samples pre-edge values regardless of statement order.
            state            <= EMPTY;
            m_q              <= VACANT;
            s_q              <= VACANT;
            ex_ready_o       <= 1'b1;
            ls_instr_last_o  <= NOP_INSTR;
            ls_alures_last_o <= '0;
        end else begin
            if (deq) begin
                ls_instr_last_o  <= m_q.instr;
                ls_alures_last_o <= m_q.alures;
            end else begin
                ls_instr_last_o  <= NOP_INSTR;
                ls_alures_last_o <= '0;
            end

            if (flush_i) begin
                state      <= EMPTY;
                m_q        <= VACANT;
                s_q        <= VACANT;
                ex_ready_o <= 1'b1;
            end else begin
                unique case (state)
                    EMPTY: begin
                        if (acc) begin
                            m_q   <= ex_entry;
                            state <= BUSY;
                        end
                    end
                    BUSY: begin
                        if (acc && deq) begin
                            m_q <= ex_entry;
                        end else if (acc) begin
                            s_q        <= ex_entry;
                            state      <= FULL;
                            ex_ready_o <= 1'b0;
                        end else if (deq) begin
                            m_q   <= VACANT;
                            state <= EMPTY;
                        end
                    end
                    FULL: begin
                        // ex_ready_o is low here, so only a dequeue can move state.
                        if (deq) begin
                            m_q        <= s_q;
                            s_q        <= VACANT;
                            state      <= BUSY;
                            ex_ready_o <= 1'b1;
                        end
                    end
                    default: begin
                        state      <= EMPTY;
                        m_q        <= VACANT;
                        s_q        <= VACANT;
                        ex_ready_o <= 1'b1;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_exls_pipe_reg.sv
// tb_exls_pipe_reg: drives exls_pipe_reg with directed scenarios and random
// traffic, comparing every cycle against a queue-based model of a two-deep
// FIFO with registered ready and last-dequeued tracking.
module tb_exls_pipe_reg;

    localparam int              XLEN = 64;
    localparam int              ILEN = 32;
    localparam logic [ILEN-1:0] NOP  = 32'h0000_0013;
    localparam int              VW   = 2 + 4 * XLEN + 2 * ILEN;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [ILEN-1:0] instr;
        logic [XLEN-1:0] alures;
        logic [XLEN-1:0] rs2;
    } ent_t;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            flush_i = 1'b0;
    logic            ex_valid_i = 1'b0;
    logic            ex_ready_o;
    logic [XLEN-1:0] ex_pc_i = '0;
    logic [ILEN-1:0] ex_instr_i = '0;
    logic [XLEN-1:0] ex_alures_i = '0;
    logic [XLEN-1:0] ex_rs2_i = '0;
    logic            ls_valid_o;
    logic            ls_ready_i = 1'b0;
    logic [XLEN-1:0] ls_pc_o;
    logic [ILEN-1:0] ls_instr_o;
    logic [XLEN-1:0] ls_alures_o;
    logic [XLEN-1:0] ls_rs2_o;
    logic [ILEN-1:0] ls_instr_last_o;
    logic [XLEN-1:0] ls_alures_last_o;

    int checks = 0;
    int failures = 0;

    // Reference model state.
    ent_t            mq[$];
    logic            m_rdy = 1'b1;
    logic [ILEN-1:0] m_last_i = NOP;
    logic [XLEN-1:0] m_last_a = '0;

    exls_pipe_reg #(.XLEN(XLEN), .ILEN(ILEN), .NOP_INSTR(NOP)) dut (
        .clk              (clk),
        .rst              (rst),
        .flush_i          (flush_i),
        .ex_valid_i       (ex_valid_i),
        .ex_ready_o       (ex_ready_o),
        .ex_pc_i          (ex_pc_i),
        .ex_instr_i       (ex_instr_i),
        .ex_alures_i      (ex_alures_i),
        .ex_rs2_i         (ex_rs2_i),
        .ls_valid_o       (ls_valid_o),
        .ls_ready_i       (ls_ready_i),
        .ls_pc_o          (ls_pc_o),
        .ls_instr_o       (ls_instr_o),
        .ls_alures_o      (ls_alures_o),
        .ls_rs2_o         (ls_rs2_o),
        .ls_instr_last_o  (ls_instr_last_o),
        .ls_alures_last_o (ls_alures_last_o)
    );

    always #5 clk = ~clk;

    function automatic logic [VW-1:0] dut_vec();
        return {ex_ready_o, ls_valid_o, ls_pc_o, ls_instr_o, ls_alures_o, ls_rs2_o,
                ls_instr_last_o, ls_alures_last_o};
    endfunction

    function automatic logic [VW-1:0] model_vec();
        ent_t h;
        h = '{pc: '0, instr: NOP, alures: '0, rs2: '0};
        if (mq.size() > 0) h = mq[0];
        return {m_rdy, mq.size() > 0, h.pc, h.instr, h.alures, h.rs2, m_last_i, m_last_a};
    endfunction

    // Advance the model with the inputs presented before this edge, then the clock.
    task automatic tick();
        logic deq, acc;
        if (rst) begin
            mq.delete();
            m_rdy    = 1'b1;
            m_last_i = NOP;
            m_last_a = '0;
        end else begin
            deq = (mq.size() > 0) && ls_ready_i;
            acc = ex_valid_i && m_rdy && !flush_i;
            if (deq) begin
                m_last_i = mq[0].instr;
                m_last_a = mq[0].alures;
                void'(mq.pop_front());
            end else begin
                m_last_i = NOP;
                m_last_a = '0;
            end
            if (flush_i) mq.delete();
            else if (acc) mq.push_back('{pc: ex_pc_i, instr: ex_instr_i,
                                         alures: ex_alures_i, rs2: ex_rs2_i});
            m_rdy = (mq.size() < 2);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input logic v, input logic [XLEN-1:0] pc, input logic [ILEN-1:0] ins,
                         input logic [XLEN-1:0] alu, input logic [XLEN-1:0] rs2);
        ex_valid_i  = v;
        ex_pc_i     = pc;
        ex_instr_i  = ins;
        ex_alures_i = alu;
        ex_rs2_i    = rs2;
    endtask

    task automatic drain();
        offer(1'b0, '0, '0, '0, '0);
        ls_ready_i = 1'b1;
        flush_i    = 1'b0;
        repeat (3) tick();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        checks++;
        if ({ex_ready_o, ls_valid_o, ls_instr_o, ls_pc_o, ls_alures_o, ls_rs2_o,
             ls_instr_last_o, ls_alures_last_o} !== {1'b1, 1'b0, NOP, 192'd0, NOP, 64'd0}) begin
            failures++;
            $display("FAIL reset_values got rdy=%b v=%b instr=%h last=%h", ex_ready_o,
                     ls_valid_o, ls_instr_o, ls_instr_last_o);
        end
        rst = 1'b0;
    endtask

    task automatic test_stream();
        logic [XLEN-1:0] pc;
        ls_ready_i = 1'b1;
        for (int i = 0; i < 5; i++) begin
            pc = 64'h8000_0000 + 64'(4 * i);
            if (i < 4) offer(1'b1, pc, 32'h0010_0093 + 32'(i << 20), pc + 64'h10, 64'(i));
            else offer(1'b0, '0, '0, '0, '0);
            tick();
            checks++;
            if (dut_vec() !== model_vec()) begin
                failures++;
                $display("FAIL stream_%0d got %h exp %h", i, dut_vec(), model_vec());
            end
            if (i < 4) begin
                checks++;
                if (ls_pc_o !== pc || ex_ready_o !== 1'b1 || ls_valid_o !== 1'b1) begin
                    failures++;
                    $display("FAIL stream_pc_%0d got pc=%h rdy=%b exp pc=%h rdy=1", i,
                             ls_pc_o, ex_ready_o, pc);
                end
            end
        end
    endtask

    task automatic test_stall_fill();
        ls_ready_i = 1'b0;
        offer(1'b1, 64'hA000, 32'h0000_A003, 64'hA1, 64'hA2);
        tick();
        offer(1'b1, 64'hB000, 32'h0000_B003, 64'hB1, 64'hB2);
        tick();
        offer(1'b0, '0, '0, '0, '0);
        checks++;
        if (ex_ready_o !== 1'b0 || ls_pc_o !== 64'hA000) begin
            failures++;
            $display("FAIL stall_full got rdy=%b pc=%h exp rdy=0 pc=a000", ex_ready_o, ls_pc_o);
        end
        tick();
        checks++;
        if (dut_vec() !== model_vec()) begin
            failures++;
            $display("FAIL stall_hold got %h exp %h", dut_vec(), model_vec());
        end
        ls_ready_i = 1'b1;
        tick();
        checks++;
        if (ls_pc_o !== 64'hB000 || ls_instr_last_o !== 32'h0000_A003 || ex_ready_o !== 1'b1) begin
            failures++;
            $display("FAIL stall_release_b got pc=%h last=%h rdy=%b exp pc=b000 last=0000a003 rdy=1",
                     ls_pc_o, ls_instr_last_o, ex_ready_o);
        end
        tick();
        checks++;
        if (ls_valid_o !== 1'b0 || ls_instr_last_o !== 32'h0000_B003 || dut_vec() !== model_vec()) begin
            failures++;
            $display("FAIL stall_release_end got v=%b last=%h exp v=0 last=0000b003",
                     ls_valid_o, ls_instr_last_o);
        end
    endtask

    task automatic test_bubble();
        ls_ready_i = 1'b1;
        offer(1'b1, 64'h8000_0100, 32'h00B5_3023, 64'h8000_1000, 64'h1234);
        tick();
        offer(1'b0, '0, '0, '0, '0);
        tick();
        checks++;
        if (ls_valid_o !== 1'b0 || ls_instr_o !== NOP || ls_instr_last_o !== 32'h00B5_3023 ||
            ls_alures_last_o !== 64'h8000_1000) begin
            failures++;
            $display("FAIL bubble_gap1 got v=%b instr=%h last=%h lastaddr=%h", ls_valid_o,
                     ls_instr_o, ls_instr_last_o, ls_alures_last_o);
        end
        tick();
        checks++;
        if (ls_valid_o !== 1'b0 || ls_instr_o !== NOP || ls_instr_last_o !== NOP ||
            ls_alures_last_o !== 64'd0) begin
            failures++;
            $display("FAIL bubble_gap2 got v=%b instr=%h last=%h lastaddr=%h", ls_valid_o,
                     ls_instr_o, ls_instr_last_o, ls_alures_last_o);
        end
        offer(1'b1, 64'h8000_0104, 32'h0005_3583, 64'h8000_1000, 64'h0);
        tick();
        checks++;
        if (ls_instr_o !== 32'h0005_3583 || dut_vec() !== model_vec()) begin
            failures++;
            $display("FAIL bubble_load got instr=%h exp 00053583", ls_instr_o);
        end
    endtask

    task automatic test_flush_full();
        ls_ready_i = 1'b0;
        offer(1'b1, 64'hC000, 32'h0000_C003, 64'hC1, 64'hC2);
        tick();
        offer(1'b1, 64'hD000, 32'h0000_D003, 64'hD1, 64'hD2);
        tick();
        flush_i    = 1'b1;
        ls_ready_i = 1'b1;
        offer(1'b1, 64'hE000, 32'h0000_E003, 64'hE1, 64'hE2);
        tick();
        flush_i = 1'b0;
        offer(1'b0, '0, '0, '0, '0);
        checks++;
        if (ls_valid_o !== 1'b0 || ex_ready_o !== 1'b1 || ls_instr_last_o !== 32'h0000_C003 ||
            ls_alures_last_o !== 64'hC1) begin
            failures++;
            $display("FAIL flush_full got v=%b rdy=%b last=%h lastaddr=%h exp v=0 rdy=1 last=0000c003",
                     ls_valid_o, ex_ready_o, ls_instr_last_o, ls_alures_last_o);
        end
        tick();
        checks++;
        if (ls_valid_o !== 1'b0 || ls_instr_last_o !== NOP || dut_vec() !== model_vec()) begin
            failures++;
            $display("FAIL flush_after got v=%b last=%h exp v=0 last=%h", ls_valid_o,
                     ls_instr_last_o, NOP);
        end
    endtask

    task automatic test_reset_mid_stall();
        ls_ready_i = 1'b0;
        offer(1'b1, 64'hF000, 32'h0000_F003, 64'hF1, 64'hF2);
        tick();
        tick();
        offer(1'b0, '0, '0, '0, '0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if ({ex_ready_o, ls_valid_o, ls_instr_o, ls_pc_o, ls_alures_o, ls_rs2_o,
             ls_instr_last_o, ls_alures_last_o} !== {1'b1, 1'b0, NOP, 192'd0, NOP, 64'd0}) begin
            failures++;
            $display("FAIL reset_mid_stall got rdy=%b v=%b instr=%h pc=%h", ex_ready_o,
                     ls_valid_o, ls_instr_o, ls_pc_o);
        end
        offer(1'b1, 64'h9000, 32'h0000_9003, 64'h91, 64'h92);
        tick();
        offer(1'b0, '0, '0, '0, '0);
        checks++;
        if (ls_valid_o !== 1'b1 || ls_pc_o !== 64'h9000 || ls_rs2_o !== 64'h92) begin
            failures++;
            $display("FAIL reset_first_offer got v=%b pc=%h rs2=%h exp v=1 pc=9000 rs2=92",
                     ls_valid_o, ls_pc_o, ls_rs2_o);
        end
    endtask

    task automatic test_random();
        int errs;
        errs = 0;
        for (int i = 0; i < 400; i++) begin
            offer($urandom_range(0, 3) != 0, {$urandom, $urandom}, $urandom,
                  {$urandom, $urandom}, {$urandom, $urandom});
            ls_ready_i = $urandom_range(0, 2) != 0;
            flush_i    = $urandom_range(0, 19) == 0;
            tick();
            checks++;
            if (dut_vec() !== model_vec()) begin
                failures++;
                errs++;
                if (errs <= 5) $display("FAIL random_%0d got %h exp %h", i, dut_vec(), model_vec());
            end
        end
        flush_i = 1'b0;
    endtask

    initial begin
        test_reset();
        test_stream();
        drain();
        test_stall_fill();
        drain();
        test_bubble();
        drain();
        test_flush_full();
        drain();
        test_reset_mid_stall();
        drain();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
